// File: rtl/sdio_mux_sequencer_pkg.sv
// Shared types and constants for the SDIO mux switch-over sequencer.
// Per-state output helpers keep the output decode in one place.
package sdio_mux_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_GATE    = 3'd2,
    ST_PWR_OFF = 3'd3,
    ST_SWITCH  = 3'd4,
    ST_PWR_ON  = 3'd5
  } seq_state_e;

  localparam logic SEL_SD   = 1'b0;
  localparam logic SEL_EMMC = 1'b1;

  // Card power is removed only around the mux flip.
  function automatic logic state_pwr_en(input seq_state_e s);
    return !((s == ST_PWR_OFF) || (s == ST_SWITCH));
  endfunction

  function automatic logic state_gate_en(input seq_state_e s);
    return (s == ST_IDLE) || (s == ST_DRAIN);
  endfunction

  function automatic logic state_busy(input seq_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/sdio_mux_sequencer_if.sv
// Control/status bundle between the SDIO control register side and the sequencer.
interface sdio_mux_sequencer_if;
  logic sel_req;
  logic bus_active;
  logic mux_sel;
  logic card_pwr_en;
  logic clk_gate_en;
  logic busy;
  logic done;
  logic timeout;

  modport master (
    output sel_req, bus_active,
    input  mux_sel, card_pwr_en, clk_gate_en, busy, done, timeout
  );

  modport slave (
    input  sel_req, bus_active,
    output mux_sel, card_pwr_en, clk_gate_en, busy, done, timeout
  );
endinterface

// File: rtl/sdio_mux_sequencer_chk.sv
// Checks that the mux select only ever moves while the card is unpowered and its clock gated.
module sdio_mux_sequencer_chk (
  input logic pclk,
  input logic preset,
  input logic mux_sel,
  input logic card_pwr_en,
  input logic clk_gate_en
);

  logic prev_mux_r;
  logic prev_rst_r;

  // History of the select and reset so a change can be attributed to the previous edge.
  always_ff @(posedge pclk) begin
    prev_mux_r <= mux_sel;
    prev_rst_r <= preset;
  end

  // A reset-driven return to the reset select is exempt.
  a_mux_safe: assert property (@(posedge pclk)
    (!preset && !prev_rst_r && (mux_sel != prev_mux_r)) |-> (!card_pwr_en && !clk_gate_en));

endmodule

// File: rtl/sdio_mux_sequencer_timer.sv
// Down-counter used for per-state dwell times; load wins, then counts to zero and holds.
module sdio_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Counter register: load on state entry, otherwise decrement toward zero.
  always_ff @(posedge pclk) begin
    if (preset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sdio_mux_sequencer.sv
// Sequences a safe switch-over of the shared SDIO mux between SD card and eMMC:
// drain, gate clock, power off, flip, power on and settle, ungate.
module sdio_mux_sequencer
  import sdio_mux_sequencer_pkg::*;
#(
  parameter logic RESET_SEL     = SEL_SD,
  parameter int   GATE_CYCLES   = 2,
  parameter int   OFF_CYCLES    = 4,
  parameter int   SETTLE_CYCLES = 8,
  parameter int   DRAIN_TIMEOUT = 64,
  parameter int   CNT_W         = 8
) (
  input logic                  pclk,
  input logic                  preset,
  sdio_mux_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LD    = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       state_r, state_s;
  logic             target_r, target_s;
  logic             mux_sel_r, mux_sel_s;
  logic             card_pwr_en_r;
  logic             clk_gate_en_r;
  logic             busy_r;
  logic             done_r, done_s;
  logic             timeout_r, timeout_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             timer_zero_s;

  sdio_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .pclk     (pclk),
    .preset   (preset),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (timer_zero_s)
  );

  // Next-state, timer load and next registered output values.
  always_comb begin
    state_s    = state_r;
    target_s   = target_r;
    mux_sel_s  = mux_sel_r;
    timeout_s  = timeout_r;
    done_s     = 1'b0;
    load_s     = 1'b0;
    load_val_s = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.sel_req != mux_sel_r) begin
          state_s    = ST_DRAIN;
          target_s   = bus.sel_req;
          timeout_s  = 1'b0;
          load_s     = 1'b1;
          load_val_s = DRAIN_LD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // An idle bus wins over an expiring timer on the same cycle.
        if (!bus.bus_active) begin
          state_s    = ST_GATE;
          load_s     = 1'b1;
          load_val_s = GATE_LD;
        end else if (timer_zero_s) begin
          state_s    = ST_GATE;
          timeout_s  = 1'b1;
          load_s     = 1'b1;
          load_val_s = GATE_LD;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_GATE: begin
        if (timer_zero_s) begin
          state_s    = ST_PWR_OFF;
          load_s     = 1'b1;
          load_val_s = OFF_LD;
        end else begin
          state_s = ST_GATE;
        end
      end
      ST_PWR_OFF: begin
        if (timer_zero_s) begin
          state_s   = ST_SWITCH;
          mux_sel_s = target_r;
        end else begin
          state_s = ST_PWR_OFF;
        end
      end
      ST_SWITCH: begin
        state_s    = ST_PWR_ON;
        load_s     = 1'b1;
        load_val_s = SETTLE_LD;
      end
      ST_PWR_ON: begin
        if (timer_zero_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_PWR_ON;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; outputs reflect the state being entered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r       <= ST_IDLE;
      target_r      <= RESET_SEL;
      mux_sel_r     <= RESET_SEL;
      card_pwr_en_r <= 1'b1;
      clk_gate_en_r <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      target_r      <= target_s;
      mux_sel_r     <= mux_sel_s;
      card_pwr_en_r <= state_pwr_en(state_s);
      clk_gate_en_r <= state_gate_en(state_s);
      busy_r        <= state_busy(state_s);
      done_r        <= done_s;
      timeout_r     <= timeout_s;
    end
  end

  assign bus.mux_sel     = mux_sel_r;
  assign bus.card_pwr_en = card_pwr_en_r;
  assign bus.clk_gate_en = clk_gate_en_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.timeout     = timeout_r;

endmodule
